// File: rtl/hdmi_drive.sv
// hdmi_drive: free-running video timing generator (800x600 class by default) with registered sync, DE and RGB.
// Define HDMI_DRIVE_COLORBAR_EN for the 8-bar test pattern; without it, active video is solid white.
module hdmi_drive #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic       sclk,
  input  logic       rst_n,
  output logic       hs,
  output logic       vs,
  output logic       video_active,
  output logic [7:0] rdata,
  output logic [7:0] gdata,
  output logic [7:0] bdata
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SP     = (SYNC_POL != 0);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;
  logic          in_active;
  logic [23:0]   pix_color;

  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          va_q, va_d;
  logic [23:0]   rgb_q, rgb_d;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

`ifdef HDMI_DRIVE_COLORBAR_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW    = $clog2(BAR_W + 1);
  localparam logic [BW-1:0] BAR_RELOAD = BW'(BAR_W - 1);

  // Bar index tracks h_cnt / BAR_W with a down-counter instead of a divider.
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [BW-1:0] bar_left_q, bar_left_d;

  always_comb begin
    bar_idx_d  = bar_idx_q;
    bar_left_d = bar_left_q;
    if (h_wrap) begin
      bar_idx_d  = '0;
      bar_left_d = BAR_RELOAD;
    end else if (bar_left_q == '0) begin
      bar_left_d = BAR_RELOAD;
      if (bar_idx_q != 3'd7) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end
    end else begin
      bar_left_d = bar_left_q - 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bar_idx_q  <= '0;
      bar_left_q <= BAR_RELOAD;
    end else begin
      bar_idx_q  <= bar_idx_d;
      bar_left_q <= bar_left_d;
    end
  end

  always_comb begin
    case (bar_idx_q)
      3'd0:    pix_color = 24'hFFFFFF;
      3'd1:    pix_color = 24'hFFFF00;
      3'd2:    pix_color = 24'h00FFFF;
      3'd3:    pix_color = 24'h00FF00;
      3'd4:    pix_color = 24'hFF00FF;
      3'd5:    pix_color = 24'hFF0000;
      3'd6:    pix_color = 24'h0000FF;
      default: pix_color = 24'h000000;
    endcase
  end
`else
  always_comb begin
    pix_color = 24'hFFFFFF;
  end
`endif

  always_comb begin
    in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d      = ((h_cnt_q >= H_SS) && (h_cnt_q < H_SE)) ? SP : ~SP;
    vs_d      = ((v_cnt_q >= V_SS) && (v_cnt_q < V_SE)) ? SP : ~SP;
    va_d      = in_active;
    rgb_d     = in_active ? pix_color : 24'h000000;
  end

  // Output stage: everything sees the same counter snapshot, so all outputs stay aligned.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~SP;
      vs_q  <= ~SP;
      va_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      va_q  <= va_d;
      rgb_q <= rgb_d;
    end
  end

  assign hs           = hs_q;
  assign vs           = vs_q;
  assign video_active = va_q;
  assign rdata        = rgb_q[23:16];
  assign gdata        = rgb_q[15:8];
  assign bdata        = rgb_q[7:0];

endmodule

// File: tb/tb_hdmi_drive.sv
// Scoreboard bench for hdmi_drive using a reduced timing so several frames fit in a short run.
module tb_hdmi_drive;

  localparam int HA  = 18;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  localparam logic [23:0] W = 24'hFFFFFF;
`ifdef HDMI_DRIVE_COLORBAR_EN
  localparam logic [23:0] C1 = 24'hFFFF00;
  localparam logic [23:0] C4 = 24'hFF00FF;
  localparam logic [23:0] C5 = 24'hFF0000;
  localparam logic [23:0] C6 = 24'h0000FF;
  localparam logic [23:0] C7 = 24'h000000;
`else
  localparam logic [23:0] C1 = 24'hFFFFFF;
  localparam logic [23:0] C4 = 24'hFFFFFF;
  localparam logic [23:0] C5 = 24'hFFFFFF;
  localparam logic [23:0] C6 = 24'hFFFFFF;
  localparam logic [23:0] C7 = 24'hFFFFFF;
`endif

  logic       sclk;
  logic       rst_n;
  logic       hs;
  logic       vs;
  logic       video_active;
  logic [7:0] rdata;
  logic [7:0] gdata;
  logic [7:0] bdata;

  typedef struct {
    int          k;
    logic [26:0] v;
  } vec_t;

  logic [26:0] sbq[$];
  vec_t        vecs[$];
  int          n_edges = 0;
  int          checks  = 0;
  int          errors  = 0;

  hdmi_drive #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1)
  ) dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .hs(hs),
    .vs(vs),
    .video_active(video_active),
    .rdata(rdata),
    .gdata(gdata),
    .bdata(bdata)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, n_edges, act, exp);
    end
  endtask

  // Reference: pixel n after release maps to (n mod HT, n div HT mod VT).
  function automatic logic [26:0] model(input int n);
    int          h;
    int          v;
    logic        hsx;
    logic        vsx;
    logic        vax;
    logic [23:0] c;
`ifdef HDMI_DRIVE_COLORBAR_EN
    int          idx;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif
    h   = n % HT;
    v   = (n / HT) % VT;
    vax = (h < HA) && (v < VA);
    hsx = (h >= HA + HFP) && (h < HA + HFP + HSY);
    vsx = (v >= VA + VFP) && (v < VA + VFP + VSY);
    c   = 24'h000000;
    if (vax) begin
`ifdef HDMI_DRIVE_COLORBAR_EN
      idx = h / (HA / 8);
      if (idx > 7) idx = 7;
      c = bars[idx];
`else
      c = 24'hFFFFFF;
`endif
    end
    return {hsx, vsx, vax, c};
  endfunction

  function automatic vec_t mk(input int k, input logic h, input logic v, input logic a,
                              input logic [23:0] c);
    vec_t r;
    r.k = k;
    r.v = {h, v, a, c};
    return r;
  endfunction

  initial begin
    vecs.push_back(mk(1,   0, 0, 1, W));
    vecs.push_back(mk(3,   0, 0, 1, C1));
    vecs.push_back(mk(10,  0, 0, 1, C4));
    vecs.push_back(mk(12,  0, 0, 1, C5));
    vecs.push_back(mk(14,  0, 0, 1, C6));
    vecs.push_back(mk(16,  0, 0, 1, C7));
    vecs.push_back(mk(18,  0, 0, 1, C7));
    vecs.push_back(mk(19,  0, 0, 0, 24'h0));
    vecs.push_back(mk(21,  1, 0, 0, 24'h0));
    vecs.push_back(mk(23,  1, 0, 0, 24'h0));
    vecs.push_back(mk(24,  0, 0, 0, 24'h0));
    vecs.push_back(mk(27,  0, 0, 1, W));
    vecs.push_back(mk(105, 0, 0, 0, 24'h0));
    vecs.push_back(mk(131, 0, 1, 0, 24'h0));
    vecs.push_back(mk(151, 1, 1, 0, 24'h0));
    vecs.push_back(mk(183, 0, 0, 0, 24'h0));
    vecs.push_back(mk(209, 0, 0, 1, W));
  end

  // Producer: each edge out of reset yields one expected output word.
  initial begin
    forever begin
      @(posedge sclk);
      if (!rst_n) begin
        n_edges = 0;
      end else begin
        sbq.push_back(model(n_edges));
        n_edges++;
      end
    end
  end

  // Monitor: pops and compares on the falling edge, plus timing measurements.
  initial begin
    logic [26:0] obs;
    logic [26:0] expv;
    logic        prev_hs, prev_vs, prev_va;
    int          hs_rise, vs_rise, va_run, va_total;
    prev_hs = 0; prev_vs = 0; prev_va = 0;
    hs_rise = -1; vs_rise = -1; va_run = 0; va_total = 0;
    forever begin
      @(negedge sclk);
      obs = {hs, vs, video_active, rdata, gdata, bdata};
      if (!rst_n) begin
        check("reset_vals", 32'(obs), 32'h0);
        prev_hs = 0; prev_vs = 0; prev_va = 0;
        hs_rise = -1; vs_rise = -1; va_run = 0; va_total = 0;
      end else if (sbq.size() > 0) begin
        expv = sbq.pop_front();
        check("scoreboard", 32'(obs), 32'(expv));
        foreach (vecs[i]) begin
          if (vecs[i].k == n_edges) check("vector", 32'(obs), 32'(vecs[i].v));
        end
        if (hs && !prev_hs) begin
          if (hs_rise < 0) check("hs_first", n_edges, HA + HFP + 1);
          else             check("hs_period", n_edges - hs_rise, HT);
          hs_rise = n_edges;
        end
        if (!hs && prev_hs) check("hs_width", n_edges - hs_rise, HSY);
        if (vs && !prev_vs) begin
          if (vs_rise < 0) check("vs_first", n_edges, (VA + VFP) * HT + 1);
          else             check("vs_period", n_edges - vs_rise, FR);
          check("va_per_frame", va_total, HA * VA);
          va_total = 0;
          vs_rise  = n_edges;
        end
        if (!vs && prev_vs) check("vs_width", n_edges - vs_rise, VSY * HT);
        if (video_active) begin
          va_run++;
          va_total++;
        end else if (prev_va) begin
          check("va_run", va_run, HA);
          va_run = 0;
        end
        prev_hs = hs;
        prev_vs = vs;
        prev_va = video_active;
      end
    end
  end

  task automatic wait_edges(input int target);
    int guard;
    guard = 0;
    while (n_edges < target && guard < 5 * FR) begin
      @(negedge sclk);
      guard++;
    end
    check("wait_edges", 32'(n_edges >= target), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #2 rst_n = 1'b1;
    wait_edges(3 * FR + 2 * HT + 5);
    @(negedge sclk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({hs, vs, video_active, rdata, gdata, bdata}), 32'h0);
    repeat (5) @(posedge sclk);
    #2 rst_n = 1'b1;
    wait_edges(2 * FR + 5);
    @(negedge sclk);
    @(negedge sclk);
    check("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_drive.md
HDMI_DRIVE -- requirements
Module: hdmi_drive

Interface
REQ-001 Param H_ACTIVE, 800, visible pixels per line.
REQ-002 Param H_FP, 56, horizontal front porch (clocks).
REQ-003 Param H_SYNC, 120, horizontal sync width (clocks).
REQ-004 Param H_BP, 64, horizontal back porch (clocks).
REQ-005 Param V_ACTIVE, 600, visible lines per frame.
REQ-006 Param V_FP, 37, vertical front porch (lines).
REQ-007 Param V_SYNC, 6, vertical sync width (lines).
REQ-008 Param V_BP, 23, vertical back porch (lines).
REQ-009 Param SYNC_POL, 1, asserted level of hs/vs (1 = active-high).
REQ-010 sclk  input  1  pixel clock, 50 MHz nominal; the block has exactly one clock, all logic on its rising edge.
REQ-011 rst_n  input  1  reset, asynchronous, active-low.
REQ-012 hs  output  1  horizontal sync.
REQ-013 vs  output  1  vertical sync.
REQ-014 video_active  output  1  high during visible pixels.
REQ-015 rdata  output  8  red pixel value.
REQ-016 gdata  output  8  green pixel value.
REQ-017 bdata  output  8  blue pixel value.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1040 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (666 by default).
REQ-019 h_cnt counts 0..H_TOTAL-1 once per clock and wraps to 0; v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0 when both counters are at their maximum.
REQ-020 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-021 hs asserted (=SYNC_POL) while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise it is !SYNC_POL.
REQ-022 vs asserted (=SYNC_POL) while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise it is !SYNC_POL.
REQ-023 All outputs are registered: the value at clock k reflects the counter values at clock k-1, giving uniform 1-cycle latency with hs, vs, video_active and RGB mutually aligned.
REQ-024 Outside the active region, rdata/gdata/bdata are 0.
REQ-025 Bar width = H_ACTIVE/8 (integer division); bar index = h_cnt/bar width, saturated at 7.
REQ-026 Bar colours, index 0..7: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000 (R,G,B hex).
REQ-027 Frame timing is free-running, with no inputs other than the clock and reset.

Reset
REQ-028 While rst_n is low: h_cnt = 0, v_cnt = 0, hs = vs = !SYNC_POL, video_active = 0, rdata = gdata = bdata = 0, asynchronously.
REQ-029 After rst_n rises, the first rising edge produces outputs for h_cnt = 0, v_cnt = 0 (video_active = 1, white).
REQ-030 Reset asserted mid-frame aborts the frame; the next frame restarts at pixel (0,0) after release.

Configuration
REQ-031 Macro HDMI_DRIVE_COLORBAR_EN defined: RGB follows the 8-bar pattern of REQ-025 and REQ-026.
REQ-032 Macro HDMI_DRIVE_COLORBAR_EN undefined: RGB = FFFFFF (solid white) throughout the active region; timing is unchanged.

Verification
REQ-033 Release reset, count clocks -> hs period 1040, asserted for 120, first assertion starting 857 clocks after the first post-reset edge (h_cnt = 856 + 1 latency).
REQ-034 Measure vs -> period 692,640 clocks (13.853 ms at 50 MHz), asserted 6,240 clocks, rising edge coincident with the hs-period start at line 637.
REQ-035 Count video_active -> exactly 800 contiguous high clocks per line, 600 lines per frame, 480,000 per frame; RGB = 0 whenever video_active = 0.
REQ-036 With HDMI_DRIVE_COLORBAR_EN defined, sample line 0 -> pixels 0..99 FFFFFF, pixel 100 FFFF00, pixel 699 0000FF, pixels 700..799 000000.
REQ-037 Assert rst_n low at line 300 pixel 400 for 5 clocks -> outputs go immediately to reset values; after release, the frame restarts at (0,0) and the vs period from release to next vs edge = 637×1040+1 clocks.
REQ-038 Run 50 ms of simulation -> at least 3 complete frames, with no counter overrun and identical timing per frame.
